at_hazard_unit: RTL

//  Hazard and forwarding unit for the 5-stage MIPS pipeline. Consumes the D-stage A/T

---
 rtl/at_hazard_unit_pkg.sv | 85 ++++++++
 rtl/at_hazard_unit_stage_reg.sv | 31 +++
 rtl/at_hazard_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/at_hazard_unit_pkg.sv
// Shared definitions for the A/T hazard unit.
//  - result-source codes carried in each A/T record
//  - forwarding-mux select encodings
//  - Tuse flag bit positions within tuse_d
//  - the A/T record type, its bubble value and the compare/decode helpers
package at_hazard_unit_pkg;

    // Result source of an instruction (where its written value comes from)
    localparam logic [2:0] RES_NW  = 3'd0;  // no write
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;  // link address (jal/jalr)

    // Forwarding-mux selects
    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_E  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_W  = 2'd3;

    // Bit positions of the Tuse flags in tuse_d = {rs0, rs1, rt0, rt1, rt2}
    localparam int unsigned TUSE_RS0 = 4;
    localparam int unsigned TUSE_RS1 = 3;
    localparam int unsigned TUSE_RT0 = 2;
    localparam int unsigned TUSE_RT1 = 1;
    localparam int unsigned TUSE_RT2 = 0;

    typedef struct packed {
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [4:0] wa;
        logic [2:0] res;
    } at_rec_t;

    localparam int unsigned REC_W = $bits(at_rec_t);

    localparam at_rec_t REC_BUBBLE = '{ra1: 5'd0, ra2: 5'd0, wa: 5'd0, res: RES_NW};

    // A stage produces register a: $0 and no-write records never match
    function automatic logic at_match(input logic [4:0] a, input at_rec_t r);
        return (a != 5'd0) && (a == r.wa) && (r.res != RES_NW);
    endfunction

    // Cycles until the result exists, for an instruction sitting in E
    function automatic logic [1:0] tnew_e(input logic [2:0] res);
        logic [1:0] t;
        t = 2'd0;
        if (res == RES_ALU) t = 2'd1;
        if (res == RES_DM)  t = 2'd2;
        return t;
    endfunction

    // Cycles until the result exists, for an instruction sitting in M
    function automatic logic [1:0] tnew_m(input logic [2:0] res);
        return (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    // D-stage operand select: youngest ready producer wins
    function automatic logic [1:0] sel_d(input logic [4:0] a, input at_rec_t e,
                                         input at_rec_t m, input at_rec_t w);
        logic [1:0] s;
        s = SEL_RF;
        if (at_match(a, e) && (e.res == RES_PC)) begin
            s = SEL_E;
        end else if (at_match(a, m) && (tnew_m(m.res) == 2'd0)) begin
            s = SEL_M;
        end else if (at_match(a, w)) begin
            s = SEL_W;
        end
        return s;
    endfunction

    // E-stage operand select
    function automatic logic [1:0] sel_e(input logic [4:0] a, input at_rec_t m,
                                         input at_rec_t w);
        logic [1:0] s;
        s = SEL_RF;
        if (at_match(a, m) && (tnew_m(m.res) == 2'd0)) begin
            s = SEL_M;
        end else if (at_match(a, w)) begin
            s = SEL_W;
        end
        return s;
    endfunction

endpackage

// File: rtl/at_hazard_unit_stage_reg.sv
// at_stage_reg: one pipeline A/T record register.
//  clk      in  pipeline clock
//  reset    in  asynchronous active-low clear to bubble
//  i_bubble in  load the bubble record instead of i_rec
//  i_rec    in  record from the previous stage
//  o_rec    out registered record
module at_stage_reg
    import at_hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_bubble,
    input  logic [REC_W-1:0] i_rec,
    output logic [REC_W-1:0] o_rec
);

    logic [REC_W-1:0] r_rec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rec <= REC_BUBBLE;
        end else if (i_bubble) begin
            r_rec <= REC_BUBBLE;
        end else begin
            r_rec <= i_rec;
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/at_hazard_unit.sv
// at_hazard_unit: stall / forwarding / mult-div interlock for the 5-stage MIPS pipeline.
//  Inputs : D-stage A/T code (ra1_d, ra2_d, wa_d, tuse_d, res_d), md_d,
//           E-stage mult/div issue (md_start_e, md_div_e), clk, reset (async, active-low)
//  Outputs: stall, flush_e, md_busy (registered), fwd_rs_d/fwd_rt_d/fwd_rs_e/fwd_rt_e
//           (2-bit selects), fwd_rt_m (1 = take W result for store data)
module at_hazard_unit
    import at_hazard_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ra1_d,
    input  logic [4:0] ra2_d,
    input  logic [4:0] wa_d,
    input  logic [4:0] tuse_d,
    input  logic [2:0] res_d,
    input  logic       md_d,
    input  logic       md_start_e,
    input  logic       md_div_e,
    output logic       stall,
    output logic       flush_e,
    output logic       md_busy,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       fwd_rt_m
);

    localparam int unsigned MdMax = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW  = $clog2(MdMax + 1);

    at_rec_t w_rec_d;
    at_rec_t w_rec_e;
    at_rec_t w_rec_m;
    at_rec_t w_rec_w;

    assign w_rec_d = '{ra1: ra1_d, ra2: ra2_d, wa: wa_d, res: res_d};

    // ---------------------------------------------------------------- records
    at_stage_reg u_rec_e (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (flush_e),
        .i_rec    (w_rec_d),
        .o_rec    (w_rec_e)
    );

    at_stage_reg u_rec_m (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_rec    (w_rec_e),
        .o_rec    (w_rec_m)
    );

    at_stage_reg u_rec_w (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_rec    (w_rec_m),
        .o_rec    (w_rec_w)
    );

    // Source addresses of M/W are not needed except M.ra2 (store data)
    logic w_unused;
    assign w_unused = ^{w_rec_m.ra1, w_rec_w.ra1, w_rec_w.ra2};

    // ---------------------------------------------------------------- Tuse / Tnew
    logic       w_rs_used;
    logic       w_rt_used;
    logic [1:0] w_rs_tuse;
    logic [1:0] w_rt_tuse;
    logic [1:0] w_tnew_e;
    logic [1:0] w_tnew_m;

    assign w_rs_used = tuse_d[TUSE_RS0] | tuse_d[TUSE_RS1];
    assign w_rt_used = tuse_d[TUSE_RT0] | tuse_d[TUSE_RT1] | tuse_d[TUSE_RT2];
    assign w_rs_tuse = tuse_d[TUSE_RS0] ? 2'd0 : 2'd1;
    assign w_rt_tuse = tuse_d[TUSE_RT0] ? 2'd0 : (tuse_d[TUSE_RT1] ? 2'd1 : 2'd2);
    assign w_tnew_e  = tnew_e(w_rec_e.res);
    assign w_tnew_m  = tnew_m(w_rec_m.res);

    // ---------------------------------------------------------------- stall
    logic w_stall_at;
    logic w_stall_md;

    assign w_stall_at =
        (w_rs_used && at_match(ra1_d, w_rec_e) && (w_rs_tuse < w_tnew_e)) ||
        (w_rs_used && at_match(ra1_d, w_rec_m) && (w_rs_tuse < w_tnew_m)) ||
        (w_rt_used && at_match(ra2_d, w_rec_e) && (w_rt_tuse < w_tnew_e)) ||
        (w_rt_used && at_match(ra2_d, w_rec_m) && (w_rt_tuse < w_tnew_m));

    // md_start_e covers the issue cycle, before the counter has loaded
    assign w_stall_md = md_d && (md_busy || md_start_e);

    assign stall   = w_stall_at | w_stall_md;
    assign flush_e = stall;

    // ---------------------------------------------------------------- forwarding
    assign fwd_rs_d = sel_d(ra1_d, w_rec_e, w_rec_m, w_rec_w);
    assign fwd_rt_d = sel_d(ra2_d, w_rec_e, w_rec_m, w_rec_w);
    assign fwd_rs_e = sel_e(w_rec_e.ra1, w_rec_m, w_rec_w);
    assign fwd_rt_e = sel_e(w_rec_e.ra2, w_rec_m, w_rec_w);
    assign fwd_rt_m = at_match(w_rec_m.ra2, w_rec_w);

    // ---------------------------------------------------------------- mult/div busy
    logic [CntW-1:0] r_md_cnt;
    logic [CntW-1:0] w_md_cnt_nxt;
    logic            r_md_busy;

    always_comb begin
        w_md_cnt_nxt = r_md_cnt;
        if (md_start_e) begin
            w_md_cnt_nxt = md_div_e ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            w_md_cnt_nxt = r_md_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt  <= '0;
            r_md_busy <= 1'b0;
        end else begin
            r_md_cnt  <= w_md_cnt_nxt;
            r_md_busy <= (w_md_cnt_nxt != '0);
        end
    end

    assign md_busy = r_md_busy;

endmodule
